// File: rtl/rpn_stack_ctrl.sv
// -----------------------------------------------------------------------------
// rpn_stack_ctrl
//
// Reverse-Polish evaluator that sits in front of a LIFO stack and sequences
// all of its accesses. Operand tokens are pushed. Operator tokens pop their
// operands, apply a B-bit ALU operation and push the result. DUP, DROP and
// RESULT manipulate the top of the stack. The controller keeps its own depth
// count, so it never pushes a full stack and never pops an empty one. A token
// that would do either is refused and sets a sticky error flag instead.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset (shared
//                         with the stack)
//   tok_valid/tok_ready   token handshake; a token is accepted in IDLE only
//   tok_is_op             1 = operator token (opcode in tok_data[2:0]),
//                         0 = operand token
//   tok_data              operand value or opcode
//   err_clr               clears the sticky error flags (a set in the same
//                         cycle wins)
//   stk_push/stk_pop      stack strobes, never asserted together
//   stk_wdata             stack write data
//   stk_rdata             stack top-of-stack (combinational from the stack)
//   res_valid/res_data    one-cycle result strobe; res_data holds its value
//                         until the next RESULT
//   depth                 current stack occupancy, 0..2**W
//   err_unf/err_ovf       sticky underflow / overflow flags
// -----------------------------------------------------------------------------
module rpn_stack_ctrl #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_is_op,
  input  logic [B-1:0] tok_data,
  input  logic         err_clr,
  output logic         stk_push,
  output logic         stk_pop,
  output logic [B-1:0] stk_wdata,
  input  logic [B-1:0] stk_rdata,
  output logic         res_valid,
  output logic [B-1:0] res_data,
  output logic [W:0]   depth,
  output logic         err_unf,
  output logic         err_ovf
);

  localparam int         CAP  = 2 ** W;
  localparam logic [W:0] FULL = CAP[W:0];

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_AND    = 3'd2;
  localparam logic [2:0] OP_OR     = 3'd3;
  localparam logic [2:0] OP_XOR    = 3'd4;
  localparam logic [2:0] OP_DUP    = 3'd5;
  localparam logic [2:0] OP_DROP   = 3'd6;
  localparam logic [2:0] OP_RESULT = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP_B,
    POP_A,
    PUSH_R,
    DROP,
    OUT
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [B-1:0] hold_q;
  logic [B-1:0] hold_d;
  logic         hold_ld;
  logic [2:0]   opc_q;
  logic         opc_ld;
  logic [B-1:0] opnd_a;
  logic [B-1:0] opnd_b;
  logic [B-1:0] alu_y;
  logic         set_unf;
  logic         set_ovf;

  // ALU for binary operators. b was the top entry and a the one beneath it,
  // so SUB is a - b. Results wrap modulo 2**B.
  always_comb begin
    alu_y = '0;
    case (opc_q)
      OP_ADD:  alu_y = opnd_a + opnd_b;
      OP_SUB:  alu_y = opnd_a - opnd_b;
      OP_AND:  alu_y = opnd_a & opnd_b;
      OP_OR:   alu_y = opnd_a | opnd_b;
      OP_XOR:  alu_y = opnd_a ^ opnd_b;
      default: alu_y = '0;
    endcase
  end

  // Next-state and stack strobe decode. All acceptance decisions are made in
  // IDLE against the current depth. A token that would underflow or overflow
  // is consumed in its acceptance cycle, sets its error flag and does not
  // touch the stack. DUP captures the top of stack at acceptance, so it can
  // reuse the plain PUSH state.
  always_comb begin
    state_nxt = state;
    tok_ready = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_wdata = '0;
    hold_ld   = 1'b0;
    hold_d    = tok_data;
    opc_ld    = 1'b0;
    set_unf   = 1'b0;
    set_ovf   = 1'b0;
    case (state)
      IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          if (!tok_is_op) begin
            if (depth == FULL) begin
              set_ovf = 1'b1;
            end else begin
              hold_ld   = 1'b1;
              state_nxt = PUSH;
            end
          end else begin
            case (tok_data[2:0])
              OP_DUP: begin
                if (depth == '0) begin
                  set_unf = 1'b1;
                end else if (depth == FULL) begin
                  set_ovf = 1'b1;
                end else begin
                  hold_ld   = 1'b1;
                  hold_d    = stk_rdata;
                  state_nxt = PUSH;
                end
              end
              OP_DROP: begin
                if (depth == '0) set_unf = 1'b1;
                else             state_nxt = DROP;
              end
              OP_RESULT: begin
                if (depth == '0) set_unf = 1'b1;
                else             state_nxt = OUT;
              end
              default: begin
                if (depth < (W+1)'(2)) begin
                  set_unf = 1'b1;
                end else begin
                  opc_ld    = 1'b1;
                  state_nxt = POP_B;
                end
              end
            endcase
          end
        end
      end
      PUSH: begin
        stk_push  = 1'b1;
        stk_wdata = hold_q;
        state_nxt = IDLE;
      end
      POP_B: begin
        stk_pop   = 1'b1;
        state_nxt = POP_A;
      end
      POP_A: begin
        stk_pop   = 1'b1;
        state_nxt = PUSH_R;
      end
      PUSH_R: begin
        stk_push  = 1'b1;
        stk_wdata = alu_y;
        state_nxt = IDLE;
      end
      DROP: begin
        stk_pop   = 1'b1;
        state_nxt = IDLE;
      end
      OUT: begin
        stk_pop   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the operand/opcode latches. The stack updates its
  // top one cycle after each pop, so b is captured in POP_B and a in POP_A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      hold_q <= '0;
      opc_q  <= '0;
      opnd_a <= '0;
      opnd_b <= '0;
    end else begin
      state <= state_nxt;
      if (hold_ld)         hold_q <= hold_d;
      if (opc_ld)          opc_q  <= tok_data[2:0];
      if (state == POP_B)  opnd_b <= stk_rdata;
      if (state == POP_A)  opnd_a <= stk_rdata;
    end
  end

  // Depth follows the strobes actually sent to the stack, so it always
  // equals pushes minus pops since reset. The error flags are sticky, and a
  // new error in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth   <= '0;
      err_unf <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (stk_push)     depth <= depth + (W+1)'(1);
      else if (stk_pop) depth <= depth - (W+1)'(1);
      err_unf <= set_unf | (err_unf & ~err_clr);
      err_ovf <= set_ovf | (err_ovf & ~err_clr);
    end
  end

  // Result path. The top of stack is registered while OUT pops it, and the
  // strobe shows up in the cycle after OUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= (state == OUT);
      if (state == OUT) res_data <= stk_rdata;
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rpn_stack_ctrl
//
// Self-checking bench for rpn_stack_ctrl (B = 8, W = 2, so the stack holds 4
// entries). A behavioural LIFO model stands in for the stack block. The
// reference model keeps a queue of stack contents and evaluates every token
// arithmetically. After each token the bench compares depth, error flags,
// busy cycles, stack access counts and the result against that model.
// -----------------------------------------------------------------------------
module tb_rpn_stack_ctrl;

  localparam int B   = 8;
  localparam int W   = 2;
  localparam int CAP = 2 ** W;

  logic         clk;
  logic         reset;
  logic         tok_valid;
  logic         tok_ready;
  logic         tok_is_op;
  logic [B-1:0] tok_data;
  logic         err_clr;
  logic         stk_push;
  logic         stk_pop;
  logic [B-1:0] stk_wdata;
  logic [B-1:0] stk_rdata;
  logic         res_valid;
  logic [B-1:0] res_data;
  logic [W:0]   depth;
  logic         err_unf;
  logic         err_ovf;

  int checks   = 0;
  int failures = 0;

  // Behavioural stack: storage, pointer and access counters.
  logic [B-1:0] stk_mem [CAP];
  int           sp = 0;
  int           push_count = 0;
  int           pop_count  = 0;

  // Reference model state.
  int ref_q[$];
  int last_res = 0;
  bit exp_unf  = 0;
  bit exp_ovf  = 0;

  rpn_stack_ctrl #(.B(B), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_is_op (tok_is_op),
    .tok_data  (tok_data),
    .err_clr   (err_clr),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .res_valid (res_valid),
    .res_data  (res_data),
    .depth     (depth),
    .err_unf   (err_unf),
    .err_ovf   (err_ovf)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The stack presents its top entry combinationally.
  always_comb begin
    stk_rdata = '0;
    if (sp > 0 && sp <= CAP) stk_rdata = stk_mem[sp-1];
  end

  // Stack state update; it shares the controller's reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0;
    end else if (stk_push) begin
      if (sp < CAP) stk_mem[sp] <= stk_wdata;
      sp <= sp + 1;
    end else if (stk_pop) begin
      sp <= sp - 1;
    end
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Mid-cycle protocol monitor: the strobes are exclusive, the stack is
  // never pushed when full or popped when empty, and accesses are counted.
  always @(negedge clk) begin
    if (!reset) begin
      if (stk_push || stk_pop)
        checkOutput("push_pop_exclusive", {31'd0, stk_push & stk_pop}, 32'd0);
      if (stk_push) begin
        checkOutput("push_not_full", (sp < CAP) ? 32'd1 : 32'd0, 32'd1);
        push_count++;
      end
      if (stk_pop) begin
        checkOutput("pop_not_empty", (sp > 0) ? 32'd1 : 32'd0, 32'd1);
        pop_count++;
      end
    end
  end

  function automatic int aluRef(input int code, input int a, input int b);
    case (code)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return a & b;
      3:       return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Present one token and evaluate it against the queue model.
  task automatic applyStimulus(input bit is_op, input logic [B-1:0] data,
                               input bit clr);
    int  exp_push = 0;
    int  exp_pop  = 0;
    int  exp_busy = 0;
    bit  is_res   = 0;
    bit  unf      = 0;
    bit  ovf      = 0;
    int  a, b, busy, push0, pop0;
    if (!is_op) begin
      if (ref_q.size() == CAP) ovf = 1;
      else begin ref_q.push_back(int'(data)); exp_push = 1; exp_busy = 1; end
    end else begin
      case (int'(data[2:0]))
        5: begin
          if (ref_q.size() == 0) unf = 1;
          else if (ref_q.size() == CAP) ovf = 1;
          else begin ref_q.push_back(ref_q[$]); exp_push = 1; exp_busy = 1; end
        end
        6: begin
          if (ref_q.size() == 0) unf = 1;
          else begin void'(ref_q.pop_back()); exp_pop = 1; exp_busy = 1; end
        end
        7: begin
          if (ref_q.size() == 0) unf = 1;
          else begin
            last_res = ref_q.pop_back();
            exp_pop = 1; exp_busy = 1; is_res = 1;
          end
        end
        default: begin
          if (ref_q.size() < 2) unf = 1;
          else begin
            b = ref_q.pop_back();
            a = ref_q.pop_back();
            ref_q.push_back(aluRef(int'(data[2:0]), a, b));
            exp_pop = 2; exp_push = 1; exp_busy = 3;
          end
        end
      endcase
    end
    if (clr) begin exp_unf = 0; exp_ovf = 0; end
    exp_unf |= unf;
    exp_ovf |= ovf;

    @(negedge clk);
    checkOutput("ready_before_token", {31'd0, tok_ready}, 32'd1);
    push0     = push_count;
    pop0      = pop_count;
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = data;
    err_clr   = clr;
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    err_clr   = 1'b0;
    busy      = 0;
    while (!tok_ready && busy < 20) begin
      @(posedge clk);
      #1;
      busy++;
    end
    checkOutput("busy_cycles", busy, exp_busy);
    checkOutput("depth", {29'd0, depth}, ref_q.size());
    checkOutput("err_unf", {31'd0, err_unf}, {31'd0, exp_unf});
    checkOutput("err_ovf", {31'd0, err_ovf}, {31'd0, exp_ovf});
    checkOutput("push_count", push_count - push0, exp_push);
    checkOutput("pop_count", pop_count - pop0, exp_pop);
    checkOutput("res_valid", {31'd0, res_valid}, {31'd0, is_res});
    checkOutput("res_data", {24'd0, res_data}, last_res);
    if (is_res) begin
      @(posedge clk);
      #1;
      checkOutput("res_valid_one_cycle", {31'd0, res_valid}, 32'd0);
      checkOutput("res_data_hold", {24'd0, res_data}, last_res);
    end
  endtask

  task automatic opnd(input int v);
    applyStimulus(1'b0, B'(v), 1'b0);
  endtask

  task automatic oper(input int code);
    applyStimulus(1'b1, B'(code), 1'b0);
  endtask

  // Check every controller output against its reset value.
  task automatic checkResetState();
    checkOutput("rst_tok_ready", {31'd0, tok_ready}, 32'd1);
    checkOutput("rst_depth", {29'd0, depth}, 32'd0);
    checkOutput("rst_err_unf", {31'd0, err_unf}, 32'd0);
    checkOutput("rst_err_ovf", {31'd0, err_ovf}, 32'd0);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_res_data", {24'd0, res_data}, 32'd0);
    checkOutput("rst_stk_push", {31'd0, stk_push}, 32'd0);
    checkOutput("rst_stk_pop", {31'd0, stk_pop}, 32'd0);
    checkOutput("rst_stk_wdata", {24'd0, stk_wdata}, 32'd0);
  endtask

  // Directed scenarios first, then a long randomized token stream.
  initial begin
    reset     = 1'b1;
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_data  = '0;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    reset = 1'b0;

    // 3 + 4 = 7; 10 - 3 = 7; 3 - 10 = 249; 200 + 100 = 44.
    opnd(3);  opnd(4);   oper(0); oper(7);
    opnd(10); opnd(3);   oper(1); oper(7);
    opnd(3);  opnd(10);  oper(1); oper(7);
    opnd(200); opnd(100); oper(0); oper(7);
    // 0xF0 with 0x3C: AND 0x30, OR 0xFC, XOR 0xCC.
    opnd(8'hF0); opnd(8'h3C); oper(2); oper(7);
    opnd(8'hF0); opnd(8'h3C); oper(3); oper(7);
    opnd(8'hF0); opnd(8'h3C); oper(4); oper(7);

    // Fill the stack: the fifth operand overflows, DUP on a full stack too.
    opnd(1); opnd(2); opnd(3); opnd(4); opnd(5);
    oper(5);
    applyStimulus(1'b1, B'(6), 1'b1);
    oper(6); oper(6); oper(6);

    // Empty stack underflows, then 9 DUP ADD gives 18.
    oper(0); oper(6); oper(7);
    applyStimulus(1'b0, B'(9), 1'b1);
    oper(5); oper(0); oper(7);

    // Reset while an ADD is in POP_A; the token and stack contents are lost.
    opnd(5); opnd(6);
    @(negedge clk);
    tok_valid = 1'b1;
    tok_is_op = 1'b1;
    tok_data  = B'(0);
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_op_pop", {31'd0, stk_pop}, 32'd1);
    reset = 1'b1;
    #1;
    checkResetState();
    @(negedge clk);
    reset = 1'b0;
    ref_q.delete();
    last_res = 0;
    exp_unf  = 0;
    exp_ovf  = 0;
    opnd(1); oper(7);

    // Random token stream; operators carry random upper data bits.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 55, B'($urandom),
                    $urandom_range(0, 9) == 0);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
